// File: rtl/piradip_axi4mmlite_manager_if.sv
// AXI4-Lite bus bundle between a manager and a subordinate.
// Signals (manager view): AW channel (m_awaddr, m_awprot, m_awvalid / m_awready),
// W channel (m_wdata, m_wstrb, m_wvalid / m_wready), B channel (m_bresp, m_bvalid /
// m_bready), AR channel (m_araddr, m_arprot, m_arvalid / m_arready) and R channel
// (m_rdata, m_rresp, m_rvalid / m_rready).
// Modports: master = manager side, slave = subordinate side.
interface piradip_axi4mmlite_manager_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0]   m_awaddr;
    logic [2:0]              m_awprot;
    logic                    m_awvalid;
    logic                    m_awready;
    logic [DATA_WIDTH-1:0]   m_wdata;
    logic [DATA_WIDTH/8-1:0] m_wstrb;
    logic                    m_wvalid;
    logic                    m_wready;
    logic [1:0]              m_bresp;
    logic                    m_bvalid;
    logic                    m_bready;
    logic [ADDR_WIDTH-1:0]   m_araddr;
    logic [2:0]              m_arprot;
    logic                    m_arvalid;
    logic                    m_arready;
    logic [DATA_WIDTH-1:0]   m_rdata;
    logic [1:0]              m_rresp;
    logic                    m_rvalid;
    logic                    m_rready;

    modport master (
        output m_awaddr, m_awprot, m_awvalid, input m_awready,
        output m_wdata, m_wstrb, m_wvalid, input m_wready,
        input m_bresp, m_bvalid, output m_bready,
        output m_araddr, m_arprot, m_arvalid, input m_arready,
        input m_rdata, m_rresp, m_rvalid, output m_rready
    );

    modport slave (
        input m_awaddr, m_awprot, m_awvalid, output m_awready,
        input m_wdata, m_wstrb, m_wvalid, output m_wready,
        output m_bresp, m_bvalid, input m_bready,
        input m_araddr, m_arprot, m_arvalid, output m_arready,
        output m_rdata, m_rresp, m_rvalid, input m_rready
    );
endinterface

// File: rtl/piradip_axi4mmlite_manager.sv
// Single-outstanding AXI4-Lite manager: turns one command (read or write) into one
// AXI4-Lite transaction and returns one response.
// Ports:
//   aclk, areset        - rising-edge clock, synchronous active-high reset
//   cmd_*               - command in (valid/ready, write flag, addr, wdata, wstrb)
//   rsp_*               - response out (valid/ready, write flag, rdata, resp)
//   timeout_err         - sticky watchdog flag (only when TIMEOUT_CYCLES > 0)
//   busy                - high whenever the FSM is not idle
//   m_axi               - AXI4-Lite manager bus (master modport)
// DATA_WIDTH must be 32 or 64.
module piradip_axi4mmlite_manager #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    timeout_err,
    output logic                    busy,
    piradip_axi4mmlite_manager_if.master m_axi
);
    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WR_ADDR_DATA = 3'd1,
        ST_WR_RESP      = 3'd2,
        ST_RD_ADDR      = 3'd3,
        ST_RD_DATA      = 3'd4,
        ST_RESPOND      = 3'd5
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_LIM  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [DATA_WIDTH/8-1:0] wstrb_r;
    logic                    write_r;
    logic                    cmd_ready_r;
    logic                    awvalid_r;
    logic                    wvalid_r;
    logic                    arvalid_r;
    logic                    bready_r;
    logic                    rready_r;
    logic                    rsp_valid_r;
    logic                    rsp_write_r;
    logic [DATA_WIDTH-1:0]   rsp_rdata_r;
    logic [1:0]              rsp_resp_r;
    logic                    timeout_err_r;
    logic [CNT_W-1:0]        cnt_r;

    // A channel counts as done once its valid has dropped or is being accepted now,
    // which lets AW and W finish in any order or together.
    logic aw_hs_s, w_hs_s, aw_done_s, w_done_s, cnt_en_s;
    assign aw_hs_s   = awvalid_r & m_axi.m_awready;
    assign w_hs_s    = wvalid_r & m_axi.m_wready;
    assign aw_done_s = ~awvalid_r | m_axi.m_awready;
    assign w_done_s  = ~wvalid_r | m_axi.m_wready;
    assign cnt_en_s  = (state_r != ST_IDLE) && (state_r != ST_RESPOND);

    // Transaction FSM, registered bus outputs, response capture and watchdog.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r       <= ST_IDLE;
            addr_r        <= {ADDR_WIDTH{1'b0}};
            wdata_r       <= {DATA_WIDTH{1'b0}};
            wstrb_r       <= {(DATA_WIDTH/8){1'b0}};
            write_r       <= 1'b0;
            cmd_ready_r   <= 1'b0;
            awvalid_r     <= 1'b0;
            wvalid_r      <= 1'b0;
            arvalid_r     <= 1'b0;
            bready_r      <= 1'b0;
            rready_r      <= 1'b0;
            rsp_valid_r   <= 1'b0;
            rsp_write_r   <= 1'b0;
            rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
            rsp_resp_r    <= 2'b00;
            timeout_err_r <= 1'b0;
            cnt_r         <= CNT_ZERO;
        end else begin
            // Watchdog only observes; it never aborts the transaction. Transitions
            // below override cnt_r so every state entry starts from zero.
            if (TIMEOUT_CYCLES > 0 && cnt_en_s) begin
                if (cnt_r != TIMEOUT_LIM) begin
                    cnt_r <= cnt_r + CNT_ONE;
                end
                if (cnt_r == TIMEOUT_LAST) begin
                    timeout_err_r <= 1'b1;
                end
            end

            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready_r) begin
                        addr_r      <= cmd_addr;
                        wdata_r     <= cmd_wdata;
                        wstrb_r     <= cmd_wstrb;
                        write_r     <= cmd_write;
                        cmd_ready_r <= 1'b0;
                        cnt_r       <= CNT_ZERO;
                        if (cmd_write) begin
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                            state_r   <= ST_WR_ADDR_DATA;
                        end else begin
                            arvalid_r <= 1'b1;
                            state_r   <= ST_RD_ADDR;
                        end
                    end else begin
                        // Also raises cmd_ready on the first cycle out of reset.
                        cmd_ready_r <= 1'b1;
                    end
                end
                ST_WR_ADDR_DATA: begin
                    if (aw_hs_s) begin
                        awvalid_r <= 1'b0;
                    end
                    if (w_hs_s) begin
                        wvalid_r <= 1'b0;
                    end
                    if (aw_done_s && w_done_s) begin
                        bready_r <= 1'b1;
                        cnt_r    <= CNT_ZERO;
                        state_r  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (m_axi.m_bvalid) begin
                        bready_r    <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_write_r <= write_r;
                        rsp_rdata_r <= {DATA_WIDTH{1'b0}};
                        rsp_resp_r  <= m_axi.m_bresp;
                        cnt_r       <= CNT_ZERO;
                        state_r     <= ST_RESPOND;
                    end
                end
                ST_RD_ADDR: begin
                    if (m_axi.m_arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        cnt_r     <= CNT_ZERO;
                        state_r   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (m_axi.m_rvalid) begin
                        rready_r    <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_write_r <= write_r;
                        rsp_rdata_r <= m_axi.m_rdata;
                        rsp_resp_r  <= m_axi.m_rresp;
                        cnt_r       <= CNT_ZERO;
                        state_r     <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_write   = rsp_write_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_resp    = rsp_resp_r;
    assign timeout_err = timeout_err_r;
    assign busy        = (state_r != ST_IDLE);

    assign m_axi.m_awaddr  = addr_r;
    assign m_axi.m_awprot  = 3'b000;
    assign m_axi.m_awvalid = awvalid_r;
    assign m_axi.m_wdata   = wdata_r;
    assign m_axi.m_wstrb   = wstrb_r;
    assign m_axi.m_wvalid  = wvalid_r;
    assign m_axi.m_bready  = bready_r;
    assign m_axi.m_araddr  = addr_r;
    assign m_axi.m_arprot  = 3'b000;
    assign m_axi.m_arvalid = arvalid_r;
    assign m_axi.m_rready  = rready_r;
endmodule

// File: tb/tb_piradip_axi4mmlite_manager.sv
// Bench for piradip_axi4mmlite_manager: a table of transactions played against a
// small configurable subordinate, a response scoreboard queue, plus hand-written
// sequences for reset behaviour and stray B/R valids while idle.
module tb_piradip_axi4mmlite_manager;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          aclk = 1'b0;
    logic          areset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          timeout_err, busy;

    piradip_axi4mmlite_manager_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    piradip_axi4mmlite_manager #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .timeout_err(timeout_err), .busy(busy),
        .m_axi(axi)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic        write;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] sub_rdata;
        logic [1:0]  sub_resp;
        int          aw_dly, w_dly, b_dly, ar_dly, r_dly, rsp_dly;
        int          exp_lat;      // cycles from accept to first rsp_valid
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          to_at;        // cycle after accept where timeout_err rises, 0 = never
    } vec_t;

    typedef struct packed {
        logic        w;
        logic [31:0] d;
        logic [1:0]  r;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cur_vec = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL [vec %0d] %s: got 0x%0h, expected 0x%0h", cur_vec, name, act, exp);
        end
    endtask

    task automatic sub_idle();
        axi.m_awready = 1'b0; axi.m_wready = 1'b0; axi.m_arready = 1'b0;
        axi.m_bvalid = 1'b0; axi.m_rvalid = 1'b0;
        axi.m_bresp = 2'b00; axi.m_rresp = 2'b00; axi.m_rdata = 32'h0;
    endtask

    // One command through the DUT with the subordinate timing given by v.
    task automatic run_txn(input int idx, input vec_t v);
        int   k, both_k, rd_k, rsp_first;
        bit   aw_done, w_done, ar_done, b_done, r_done, rsp_done;
        logic awv_p, awr_p, wv_p, wr_p, arv_p, arr_p, bv_p, br_p, rv_p, rr_p;
        exp_t e;
        cur_vec = idx;
        sub_idle();
        axi.m_bresp = v.sub_resp;
        axi.m_rresp = v.sub_resp;
        axi.m_rdata = v.write ? 32'hFFFF_FFFF : v.sub_rdata;
        @(negedge aclk);
        check("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
        sb.push_back('{v.write, v.exp_rdata, v.exp_resp});
        @(negedge aclk);
        // Scramble the command port: the DUT must use its captured copy.
        cmd_valid = 1'b0; cmd_write = ~v.write; cmd_addr = ~v.addr;
        cmd_wdata = ~v.wdata; cmd_wstrb = ~v.wstrb;
        k = 1; both_k = 0; rd_k = 0; rsp_first = 0;
        aw_done = 0; w_done = 0; ar_done = 0; b_done = 0; r_done = 0; rsp_done = 0;
        {awv_p, awr_p, wv_p, wr_p, arv_p, arr_p, bv_p, br_p, rv_p, rr_p} = '0;
        while (!rsp_done && k < 60) begin
            if (awv_p && awr_p) aw_done = 1;
            if (wv_p && wr_p) w_done = 1;
            if (arv_p && arr_p) ar_done = 1;
            if (bv_p && br_p) b_done = 1;
            if (rv_p && rr_p) r_done = 1;
            if (k == 1) begin
                check("busy_t1", busy, 1'b1);
                check("cmd_ready_t1", cmd_ready, 1'b0);
                check("awvalid_t1", axi.m_awvalid, v.write);
                check("wvalid_t1", axi.m_wvalid, v.write);
                check("arvalid_t1", axi.m_arvalid, !v.write);
            end
            if (awv_p) check(awr_p ? "awvalid_drop" : "awvalid_hold", axi.m_awvalid, !awr_p);
            if (wv_p) check(wr_p ? "wvalid_drop" : "wvalid_hold", axi.m_wvalid, !wr_p);
            if (arv_p) check(arr_p ? "arvalid_drop" : "arvalid_hold", axi.m_arvalid, !arr_p);
            if (axi.m_awvalid) begin
                check("awaddr", axi.m_awaddr, v.addr);
                check("awprot", axi.m_awprot, 3'b000);
            end
            if (axi.m_wvalid) begin
                check("wdata", axi.m_wdata, v.wdata);
                check("wstrb", axi.m_wstrb, v.wstrb);
            end
            if (axi.m_arvalid) begin
                check("araddr", axi.m_araddr, v.addr);
                check("arprot", axi.m_arprot, 3'b000);
            end
            if (v.write) check("rready_in_write", axi.m_rready, 1'b0);
            else check("bready_in_read", axi.m_bready, 1'b0);
            if (v.write && aw_done && w_done && both_k == 0) begin
                both_k = k;
                check("bready_on_wr_resp", axi.m_bready, 1'b1);
            end
            if (!v.write && ar_done && rd_k == 0) begin
                rd_k = k;
                check("rready_on_rd_data", axi.m_rready, 1'b1);
            end
            if (b_done) check("bready_after_b", axi.m_bready, 1'b0);
            check("timeout_err", timeout_err, (v.to_at != 0 && k >= v.to_at));
            // Subordinate drive for the coming edge.
            axi.m_awready = axi.m_awvalid && (k >= 1 + v.aw_dly);
            axi.m_wready  = axi.m_wvalid && (k >= 1 + v.w_dly);
            axi.m_arready = axi.m_arvalid && (k >= 1 + v.ar_dly);
            axi.m_bvalid  = (both_k != 0) && !b_done && (k >= both_k + v.b_dly);
            axi.m_rvalid  = (rd_k != 0) && !r_done && (k >= rd_k + v.r_dly);
            // Response side: compare against the scoreboard head every cycle it is offered.
            if (rsp_valid) begin
                if (rsp_first == 0) begin
                    rsp_first = k;
                    check("rsp_latency", k, v.exp_lat);
                end
                check("sb_nonempty", (sb.size() > 0), 1'b1);
                if (sb.size() > 0) begin
                    e = sb[0];
                    check("rsp_write", rsp_write, e.w);
                    check("rsp_rdata", rsp_rdata, e.d);
                    check("rsp_resp", rsp_resp, e.r);
                end
                check("cmd_ready_while_rsp", cmd_ready, 1'b0);
                rsp_ready = (k - rsp_first >= v.rsp_dly);
                if (rsp_ready) begin
                    rsp_done = 1;
                    if (sb.size() > 0) void'(sb.pop_front());
                end
            end else begin
                rsp_ready = 1'b0;
            end
            awv_p = axi.m_awvalid; awr_p = axi.m_awready;
            wv_p = axi.m_wvalid;   wr_p = axi.m_wready;
            arv_p = axi.m_arvalid; arr_p = axi.m_arready;
            bv_p = axi.m_bvalid;   br_p = axi.m_bready;
            rv_p = axi.m_rvalid;   rr_p = axi.m_rready;
            @(negedge aclk);
            k++;
        end
        check("rsp_seen", rsp_done, 1'b1);
        rsp_ready = 1'b0;
        sub_idle();
        check("rsp_valid_after_hs", rsp_valid, 1'b0);
        check("cmd_ready_after_hs", cmd_ready, 1'b1);
        check("busy_after_hs", busy, 1'b0);
        check("sb_empty", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // write, addr, wdata, wstrb, sub_rdata, sub_resp,
        // aw_dly, w_dly, b_dly, ar_dly, r_dly, rsp_dly, exp_lat, exp_rdata, exp_resp, to_at
        vecs[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 32'h0, 2'b00, 0};
        vecs[1] = '{1'b0, 8'h08, 32'h0, 4'h0, 32'h12345678, 2'b00, 0, 0, 0, 0, 5, 0, 8, 32'h12345678, 2'b00, 0};
        vecs[2] = '{1'b1, 8'h20, 32'hA5A50001, 4'h3, 32'h0, 2'b00, 3, 0, 0, 0, 0, 0, 6, 32'h0, 2'b00, 0};
        vecs[3] = '{1'b1, 8'h24, 32'h01020304, 4'hC, 32'h0, 2'b00, 0, 2, 0, 0, 0, 1, 5, 32'h0, 2'b00, 0};
        vecs[4] = '{1'b1, 8'h30, 32'h55AA55AA, 4'h5, 32'h0, 2'b11, 1, 1, 2, 0, 0, 0, 6, 32'h0, 2'b11, 0};
        vecs[5] = '{1'b0, 8'h44, 32'h0, 4'h0, 32'hCAFEF00D, 2'b10, 0, 0, 0, 0, 0, 3, 3, 32'hCAFEF00D, 2'b10, 0};
        vecs[6] = '{1'b0, 8'hFC, 32'h0, 4'h0, 32'h0BADC0DE, 2'b01, 0, 0, 0, 2, 1, 0, 6, 32'h0BADC0DE, 2'b01, 0};
        vecs[7] = '{1'b1, 8'h40, 32'h00000077, 4'h1, 32'h0, 2'b00, 0, 0, 20, 0, 0, 0, 23, 32'h0, 2'b00, 18};

        areset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        sub_idle();

        // Reset state.
        repeat (2) @(negedge aclk);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_valids", {axi.m_awvalid, axi.m_wvalid, axi.m_arvalid, rsp_valid}, 4'b0000);
        check("rst_readies", {axi.m_bready, axi.m_rready}, 2'b00);
        check("rst_timeout", timeout_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        areset = 1'b0;
        @(negedge aclk);
        check("cmd_ready_after_rst", cmd_ready, 1'b1);

        // Stray B/R valids while idle must not be accepted.
        axi.m_bvalid = 1'b1; axi.m_rvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check("idle_bready", axi.m_bready, 1'b0);
            check("idle_rready", axi.m_rready, 1'b0);
            check("idle_rsp_valid", rsp_valid, 1'b0);
            check("idle_busy", busy, 1'b0);
        end
        sub_idle();

        for (int i = 0; i < 8; i++) run_txn(i, vecs[i]);

        // Reset while waiting in WR_RESP abandons the write.
        cur_vec = 100;
        @(negedge aclk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h50;
        cmd_wdata = 32'h11112222; cmd_wstrb = 4'hF;
        @(negedge aclk);
        cmd_valid = 1'b0;
        axi.m_awready = 1'b1; axi.m_wready = 1'b1;
        @(negedge aclk);
        check("mid_bready", axi.m_bready, 1'b1);
        axi.m_awready = 1'b0; axi.m_wready = 1'b0;
        areset = 1'b1;
        @(negedge aclk);
        check("mid_rst_valids", {axi.m_awvalid, axi.m_wvalid, axi.m_arvalid, rsp_valid}, 4'b0000);
        check("mid_rst_bready", axi.m_bready, 1'b0);
        check("mid_rst_cmd_ready", cmd_ready, 1'b0);
        check("mid_rst_timeout", timeout_err, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        areset = 1'b0;
        axi.m_bvalid = 1'b1;       // late B for the abandoned write
        @(negedge aclk);
        check("post_rst_cmd_ready", cmd_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("post_rst_bready", axi.m_bready, 1'b0);
            check("post_rst_rsp_valid", rsp_valid, 1'b0);
            @(negedge aclk);
        end
        sub_idle();

        // Normal operation resumes after the aborted transaction.
        run_txn(0, vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/piradip_axi4mmlite_manager.md
PIRADIP_AXI4MMLITE_MANAGER -- requirements
Module: piradip_axi4mmlite_manager

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, AXI4-Lite address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; only 32 or 64 are legal.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 0, response watchdog limit; 0 disables the watchdog.
REQ-004 SHALL have port aclk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 SHALL have port areset, input, 1 bit; reset is synchronous and active-high.
REQ-006 SHALL have command ports cmd_valid in 1, cmd_ready out 1, cmd_write in 1 (1=write, 0=read), cmd_addr in ADDR_WIDTH, cmd_wdata in DATA_WIDTH, cmd_wstrb in DATA_WIDTH/8.
REQ-007 SHALL have response ports rsp_valid out 1, rsp_ready in 1, rsp_write out 1, rsp_rdata out DATA_WIDTH, rsp_resp out 2.
REQ-008 SHALL have AXI4-Lite manager ports m_awaddr, m_awprot(3), m_awvalid, m_awready, m_wdata, m_wstrb, m_wvalid, m_wready, m_bresp(2), m_bvalid, m_bready, m_araddr, m_arprot(3), m_arvalid, m_arready, m_rdata, m_rresp(2), m_rvalid, m_rready, with standard directions and widths.
REQ-009 SHALL have status ports timeout_err out 1 (sticky) and busy out 1 (state != IDLE).

Function
REQ-010 SHALL implement states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESPOND; at most one transaction is outstanding.
REQ-011 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on cycle T when cmd_valid & cmd_ready.
REQ-012 SHALL register cmd_addr, cmd_wdata, cmd_wstrb, cmd_write on acceptance; later command-port changes have no effect.
REQ-013 On an accepted write, SHALL assert m_awvalid and m_wvalid together at T+1 and enter WR_ADDR_DATA.
REQ-014 SHALL deassert m_awvalid the cycle after m_awready&m_awvalid, and m_wvalid after m_wready&m_wvalid, independently; AW and W completing in either order or the same cycle are all legal.
REQ-015 SHALL hold m_awaddr/m_wdata/m_wstrb stable while the respective valid is high; valid SHALL NOT drop before its handshake.
REQ-016 SHALL enter WR_RESP once both AW and W have handshaken; m_bready=1 only in WR_RESP.
REQ-017 On an accepted read, SHALL assert m_arvalid at T+1 (RD_ADDR), drop it after m_arready&m_arvalid, then enter RD_DATA with m_rready=1 only in RD_DATA.
REQ-018 On B or R handshake, SHALL capture m_bresp or m_rdata/m_rresp and enter RESPOND on the next cycle with rsp_valid=1.
REQ-019 SHALL set rsp_rdata to 0 for writes; rsp_write SHALL equal the registered cmd_write.
REQ-020 SHALL hold rsp_* stable while rsp_valid & ~rsp_ready, and return to IDLE the cycle after rsp_valid & rsp_ready.
REQ-021 Minimum latency with zero-wait subordinate: command accept T, valid T+1, B/R handshake T+2, rsp_valid T+3, next cmd_ready T+4 if rsp_ready at T+3.
REQ-022 SHALL drive m_awprot = m_arprot = 3'b000 (data, secure, unprivileged).
REQ-023 Any SLVERR/DECERR/EXOKAY response SHALL pass unmodified to rsp_resp; the block SHALL NOT retry.
REQ-024 When TIMEOUT_CYCLES>0, a counter SHALL count cycles in any state other than IDLE/RESPOND, clearing on state entry; reaching TIMEOUT_CYCLES SHALL set timeout_err=1 without aborting the transaction.
REQ-025 timeout_err SHALL clear only on reset; with TIMEOUT_CYCLES=0 it stays 0.
REQ-026 m_bvalid or m_rvalid arriving outside WR_RESP/RD_DATA SHALL be ignored (ready remains 0).

Reset
REQ-027 While areset=1 at a clock edge, SHALL force state IDLE, all *valid/*ready outputs 0 except cmd_ready, which is 0 during reset and 1 the first cycle after, rsp_* 0, timeout_err 0, counter 0.
REQ-028 Reset mid-transaction SHALL abandon it immediately; no response is produced for it.

Verification
REQ-029 Write 0xDEADBEEF, addr 0x10, wstrb 0xF, zero-wait subordinate -> m_awaddr=0x10 at T+1, rsp_valid at T+3, rsp_resp=00, rsp_write=1.
REQ-030 Read addr 0x08, subordinate returns rdata 0x12345678 after 5-cycle R delay -> rsp_rdata=0x12345678, m_rvalid ignored before RD_DATA.
REQ-031 Write with m_wready at T+1 and m_awready at T+4 -> m_wvalid low from T+2, m_awvalid high until T+4, single B accepted, one response.
REQ-032 Read with m_rresp=SLVERR, rsp_ready low 3 cycles -> rsp_resp=10 stable 3 cycles, cmd_ready low until after handshake.
REQ-033 TIMEOUT_CYCLES=16, subordinate never asserts m_bvalid for 20 cycles -> timeout_err=1 from 16 cycles after WR_RESP entry; later B still produces a response.
REQ-034 areset pulsed while in WR_RESP -> all valids 0, cmd_ready 1 cycle after release, no rsp_valid.
